// File: rtl/div_signed_seq_pkg.sv
// Shared definitions for the sequential signed divider: default sizes,
// FSM state encoding and two's-complement magnitude/negate helpers.
package div_signed_seq_pkg;

   localparam int DIV_N  = 8;
   localparam int DIV_CW = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   // Magnitude of a sign-extended 64-bit value; caller truncates to its width.
   function automatic logic [63:0] abs_w(input logic [63:0] x);
      return x[63] ? (~x + 64'd1) : x;
   endfunction

   // Two's-complement negate; caller truncates to its width.
   function automatic logic [63:0] neg_w(input logic [63:0] x);
      return ~x + 64'd1;
   endfunction

endpackage

// File: rtl/div_signed_seq_if.sv
// Start/busy/ready handshake and operand/result bus of the signed divider.
interface div_signed_seq_if
   import div_signed_seq_pkg::*;
#(
   parameter int N = DIV_N
);
   logic           start;
   logic [2*N-1:0] a;
   logic [N-1:0]   b;
   logic [N-1:0]   q;
   logic [N-1:0]   r;
   logic           busy;
   logic           ready;
   logic           ovf;
   logic           dz;

   modport master (output start, a, b, input q, r, busy, ready, ovf, dz);
   modport slave  (input start, a, b, output q, r, busy, ready, ovf, dz);
endinterface

// File: rtl/div_signed_seq_step.sv
// One combinational restoring-division step on unsigned magnitudes:
// shift {rem,quo} left, trial-subtract the divisor, keep or restore.
module div_step_u
   import div_signed_seq_pkg::*;
#(
   parameter int N = DIV_N
) (
   input  logic [N-1:0] rem_i,
   input  logic [N-1:0] quo_i,
   input  logic [N-1:0] div_i,
   output logic [N-1:0] rem_o,
   output logic [N-1:0] quo_o
);
   logic [N:0] sh;
   logic [N:0] trial;

   // Trial subtraction in N+1 bits; bit N set means the divisor did not fit.
   always_comb begin
      sh    = {rem_i, quo_i[N-1]};
      trial = sh - {1'b0, div_i};
      if (trial[N]) rem_o = sh[N-1:0];
      else          rem_o = trial[N-1:0];
      quo_o = {quo_i[N-2:0], ~trial[N]};
   end
endmodule

// File: rtl/div_signed_seq.sv
// Sequential 2N/N signed divider: magnitudes are divided one quotient bit
// per clock with a restoring step, then signs are applied in a FIX cycle.
module div_signed_seq
   import div_signed_seq_pkg::*;
#(
   parameter int N  = DIV_N,
   parameter int CW = DIV_CW
) (
   input  logic             clk,
   input  logic             clrn,
   div_signed_seq_if.slave  bus
);
   localparam logic [N-1:0] Q_POS = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0] Q_NEG = {1'b1, {(N-1){1'b0}}};

   state_t         state_q;
   logic [CW-1:0]  cnt_q;
   logic [N-1:0]   rem_q, quo_q, dvs_q;
   logic           sq_q, sr_q, dzl_q, pre_q;
   logic [N-1:0]   q_q, r_q;
   logic           busy_q, ready_q, ovf_q, dz_q;

   logic [2*N-1:0] abs_a_d;
   logic [N-1:0]   abs_b_d;
   logic [N-1:0]   rem_d, quo_d;
   logic [N-1:0]   q_d, r_d;
   logic           ovf_d;

   div_step_u #(.N(N)) u_step (
      .rem_i (rem_q),
      .quo_i (quo_q),
      .div_i (dvs_q),
      .rem_o (rem_d),
      .quo_o (quo_d)
   );

   // Operand magnitudes; the most negative values still fit unsigned.
   always_comb begin
      abs_a_d = (2*N)'(abs_w(64'(signed'(bus.a))));
      abs_b_d = N'(abs_w(64'(signed'(bus.b))));
   end

   // Sign fix-up and overflow detection on the finished magnitudes.
   always_comb begin
      ovf_d = dzl_q | pre_q | (~sq_q & (quo_q > Q_POS)) | (sq_q & (quo_q > Q_NEG));
      q_d   = sq_q ? N'(neg_w(64'(quo_q))) : quo_q;
      r_d   = sr_q ? N'(neg_w(64'(rem_q))) : rem_q;
      if (ovf_d) begin
         q_d = '0;
         r_d = '0;
      end
   end

   // FSM with datapath and registered outputs.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         sq_q    <= 1'b0;
         sr_q    <= 1'b0;
         dzl_q   <= 1'b0;
         pre_q   <= 1'b0;
         q_q     <= '0;
         r_q     <= '0;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
         ovf_q   <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  rem_q   <= abs_a_d[2*N-1:N];
                  quo_q   <= abs_a_d[N-1:0];
                  dvs_q   <= abs_b_d;
                  sq_q    <= bus.a[2*N-1] ^ bus.b[N-1];
                  sr_q    <= bus.a[2*N-1];
                  dzl_q   <= (bus.b == '0);
                  pre_q   <= (abs_a_d[2*N-1:N] >= abs_b_d);
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= CALC;
               end
            end
            CALC: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CW'(N-1)) state_q <= FIX;
            end
            FIX: begin
               q_q     <= q_d;
               r_q     <= r_d;
               ovf_q   <= ovf_d;
               dz_q    <= dzl_q;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.q     = q_q;
   assign bus.r     = r_q;
   assign bus.busy  = busy_q;
   assign bus.ready = ready_q;
   assign bus.ovf   = ovf_q;
   assign bus.dz    = dz_q;
endmodule

// File: tb/tb_div_signed_seq.sv
// Scoreboard bench for div_signed_seq: directed vectors push expected
// results; a negedge monitor pops and compares on every ready pulse.
module tb_div_signed_seq;
   localparam int N = 8;

   logic clk  = 1'b0;
   logic clrn = 1'b0;
   always #5 clk = ~clk;

   div_signed_seq_if #(.N(N)) bus ();
   div_signed_seq #(.N(N), .CW(3)) dut (.clk(clk), .clrn(clrn), .bus(bus));

   typedef struct {
      logic [7:0] q;
      logic [7:0] r;
      logic       ovf;
      logic       dz;
      int         due;
      string      nm;
   } exp_t;

   typedef struct {
      logic [15:0] a;
      logic [7:0]  b;
      logic [7:0]  q;
      logic [7:0]  r;
      logic        ovf;
      logic        dz;
      string       nm;
   } vec_t;

   exp_t sb[$];
   exp_t last_e;
   vec_t vecs[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   edge_cnt = 0;
   logic prev_ready = 1'b0;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   // Monitor: compare each completion against the oldest expectation.
   always @(negedge clk) begin
      if (clrn) begin
         if (prev_ready) begin
            chk("ready_one_cycle", 32'(bus.ready), 32'd0);
            chk({last_e.nm, "_q_hold"}, 32'(bus.q), 32'(last_e.q));
            chk({last_e.nm, "_r_hold"}, 32'(bus.r), 32'(last_e.r));
         end
         if (bus.ready) begin
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_ready: got ready=1 at edge %0d, required no pending operation", edge_cnt);
            end else begin
               last_e = sb.pop_front();
               chk({last_e.nm, "_q"}, 32'(bus.q), 32'(last_e.q));
               chk({last_e.nm, "_r"}, 32'(bus.r), 32'(last_e.r));
               chk({last_e.nm, "_ovf"}, 32'(bus.ovf), 32'(last_e.ovf));
               chk({last_e.nm, "_dz"}, 32'(bus.dz), 32'(last_e.dz));
               chk({last_e.nm, "_busy"}, 32'(bus.busy), 32'd0);
               chk({last_e.nm, "_latency"}, edge_cnt, last_e.due);
            end
         end
         prev_ready = bus.ready;
      end else begin
         prev_ready = 1'b0;
      end
   end

   // Drive start at #1 after an edge; it is sampled on the next edge.
   task automatic drive_start(input vec_t v);
      exp_t e;
      bus.a     = v.a;
      bus.b     = v.b;
      bus.start = 1'b1;
      e.q   = v.q;
      e.r   = v.r;
      e.ovf = v.ovf;
      e.dz  = v.dz;
      e.due = edge_cnt + N + 2;
      e.nm  = v.nm;
      sb.push_back(e);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.a     = 16'($urandom);
      bus.b     = 8'($urandom);
      chk({v.nm, "_busy_after_start"}, 32'(bus.busy), 32'd1);
   endtask

   task automatic issue(input vec_t v);
      @(posedge clk);
      #1;
      drive_start(v);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 40 && sb.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      if (sb.size() != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL timeout: got %0d operations still pending, required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_q"}, 32'(bus.q), 32'd0);
      chk({tag, "_r"}, 32'(bus.r), 32'd0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_ready"}, 32'(bus.ready), 32'd0);
      chk({tag, "_ovf"}, 32'(bus.ovf), 32'd0);
      chk({tag, "_dz"}, 32'(bus.dz), 32'd0);
   endtask

   initial begin
      vec_t v;
      int   due_a;

      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;

      vecs.push_back('{16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, "pos"});
      vecs.push_back('{16'hFF9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0, "neg_dvd"});
      vecs.push_back('{16'h0064, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0, "neg_dvs"});
      vecs.push_back('{16'hFF9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0, "both_neg"});
      vecs.push_back('{16'hFF80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0, "q_min"});
      vecs.push_back('{16'hFF80, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, "ovf_m1"});
      vecs.push_back('{16'h7FFF, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0, "pre_ovf"});
      vecs.push_back('{16'h0005, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, "div_zero"});
      vecs.push_back('{16'h8000, 8'h80, 8'h00, 8'h00, 1'b1, 1'b0, "min_min"});
      vecs.push_back('{16'hC000, 8'h80, 8'h00, 8'h00, 1'b1, 1'b0, "q_pos128"});
      vecs.push_back('{16'h4000, 8'h80, 8'h80, 8'h00, 1'b0, 1'b0, "q_neg128"});
      vecs.push_back('{16'h3F81, 8'h80, 8'h81, 8'h01, 1'b0, 1'b0, "q_m127"});
      vecs.push_back('{16'h0000, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0, "zero_dvd"});
      vecs.push_back('{16'hFFFF, 8'h02, 8'h00, 8'hFF, 1'b0, 1'b0, "neg_one"});
      vecs.push_back('{16'h03E8, 8'h64, 8'h0A, 8'h00, 1'b0, 1'b0, "exact"});

      // Reset state.
      #12;
      chk_zero("reset");
      clrn = 1'b1;

      // Directed vectors, one at a time.
      foreach (vecs[i]) begin
         issue(vecs[i]);
         wait_done();
      end

      // Starts pulsed at cycles 3 and 6 of an operation are ignored.
      issue('{16'h03E8, 8'h64, 8'h0A, 8'h00, 1'b0, 1'b0, "ign_start"});
      repeat (1) @(posedge clk);
      #1;
      bus.a = 16'h0005; bus.b = 8'h01; bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      bus.a = 16'hFF00; bus.b = 8'h03; bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_done();
      repeat (12) @(posedge clk);

      // Start in the ready cycle is accepted; back-to-back spacing N+2.
      issue('{16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, "b2b_a"});
      due_a = sb[0].due;
      for (int i = 0; i < 30 && edge_cnt != due_a; i++) begin
         @(posedge clk);
         #1;
      end
      chk("b2b_ready_seen", 32'(bus.ready), 32'd1);
      v = '{16'hFF9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0, "b2b_b"};
      drive_start(v);
      wait_done();

      // Asynchronous reset mid-operation aborts without a ready pulse.
      issue('{16'h0064, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0, "pre_abort"});
      wait_done();
      issue('{16'hFF9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0, "aborted"});
      repeat (3) @(posedge clk);
      #2;
      clrn = 1'b0;
      #1;
      chk_zero("abort");
      sb.delete();
      @(posedge clk);
      #2;
      clrn = 1'b1;
      repeat (15) @(posedge clk);
      #1;
      chk("after_abort_busy", 32'(bus.busy), 32'd0);
      chk("after_abort_q", 32'(bus.q), 32'd0);
      issue('{16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, "post_abort"});
      wait_done();
      repeat (3) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
